// File: rtl/pdm_modulator.sv
// Second-order CIFB delta-sigma PDM modulator fed by a small PCM sample FIFO.
// Each PCM sample is held for R output clocks; IDLE emits the 1,0,1,0 idle-zero pattern.
module pdm_modulator #(
  parameter int R          = 12,
  parameter int IN_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PREFILL    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic signed [IN_WIDTH-1:0] pcm_in,
  input  logic                       pcm_valid,
  output logic                       pcm_ready,
  output logic                       pdm_out,
  output logic                       sample_tick,
  output logic                       underflow,
  output logic                       running
);

  localparam int W1 = IN_WIDTH + 3;
  localparam int W2 = IN_WIDTH + 5;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(R);

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PREFILL_C  = CW'(PREFILL);
  localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

  // Full scale and clamp limits, carried two bits wider than each integrator
  localparam logic signed [W1+1:0] FS1  = {{(W1+2-IN_WIDTH){1'b0}}, 1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [W1+1:0] MAX1 = {3'b000, {(W1-1){1'b1}}};
  localparam logic signed [W1+1:0] MIN1 = {3'b111, {(W1-1){1'b0}}};
  localparam logic signed [W2+1:0] FS2  = {{(W2+2-IN_WIDTH){1'b0}}, 1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [W2+1:0] MAX2 = {3'b000, {(W2-1){1'b1}}};
  localparam logic signed [W2+1:0] MIN2 = {3'b111, {(W2-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state, state_next;
  logic signed [IN_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic [PW-1:0]              phase;
  logic signed [IN_WIDTH-1:0] head, x_reg;
  logic signed [W1-1:0]       int1, int1_next;
  logic signed [W2-1:0]       int2, int2_next;
  logic signed [W1+1:0]       sum1, fb1;
  logic signed [W2+1:0]       sum2, fb2;
  logic                       y;
  logic                       push, pop, start, pop_due, starve;

  function automatic logic signed [W1-1:0] sat1(input logic signed [W1+1:0] v);
    if (v > MAX1)      sat1 = MAX1[W1-1:0];
    else if (v < MIN1) sat1 = MIN1[W1-1:0];
    else               sat1 = v[W1-1:0];
  endfunction

  function automatic logic signed [W2-1:0] sat2(input logic signed [W2+1:0] v);
    if (v > MAX2)      sat2 = MAX2[W2-1:0];
    else if (v < MIN2) sat2 = MIN2[W2-1:0];
    else               sat2 = v[W2-1:0];
  endfunction

  assign head      = mem[rd_ptr];
  assign pcm_ready = (count < DEPTH_C);
  assign push      = pcm_valid && pcm_ready;
  assign start     = (state == IDLE) && enable && (count >= PREFILL_C);
  assign pop_due   = (state == RUN) && enable && (phase == PHASE_LAST);
  assign pop       = start || (pop_due && (count != '0));
  assign starve    = pop_due && (count == '0);
  assign running   = (state == RUN);

  // Sample FIFO: pushes are independent of the modulator state
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pcm_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)   state_next = RUN;
      RUN:  if (!enable) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Loop filter: both integrators use pre-update values; int2 sees the new int1
  always_comb begin
    y         = ~int2[W2-1];
    fb1       = y ? FS1 : -FS1;
    fb2       = y ? FS2 : -FS2;
    sum1      = (W1+2)'(int1) + (W1+2)'(x_reg) - fb1;
    int1_next = sat1(sum1);
    sum2      = (W2+2)'(int2) + (W2+2)'(int1_next) - fb2;
    int2_next = sat2(sum2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underflow   <= 1'b0;
      x_reg       <= '0;
      phase       <= '0;
      int1        <= '0;
      int2        <= '0;
    end else begin
      sample_tick <= pop;
      underflow   <= starve;
      if (state == IDLE) begin
        pdm_out <= ~pdm_out;
        if (start) begin
          x_reg <= head;
          phase <= '0;
          int1  <= '0;
          int2  <= '0;
        end
      end else if (!enable) begin
        // Leaving RUN: modulator state is dropped, queued samples are kept
        pdm_out <= ~pdm_out;
        x_reg   <= '0;
        phase   <= '0;
        int1    <= '0;
        int2    <= '0;
      end else begin
        pdm_out <= y;
        int1    <= int1_next;
        int2    <= int2_next;
        phase   <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
        if (pop) x_reg <= head;
      end
    end
  end

endmodule

// File: doc/pdm_modulator.md
PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 Parameter: R, 12, PDM clocks per PCM sample (upsampling factor, >= 2).
REQ-002 Parameter: IN_WIDTH, 16, signed PCM sample width.
REQ-003 Parameter: FIFO_DEPTH, 4, input sample FIFO entries (power of 2, >= 2).
REQ-004 Parameter: PREFILL, 2, FIFO occupancy required to start (1..FIFO_DEPTH).
REQ-005 Port: clk  in  1  PDM output clock; all logic on its rising edge.
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: enable  in  1  run request; low forces IDLE.
REQ-008 Port: pcm_in  in  IN_WIDTH  signed PCM sample, two's complement.
REQ-009 Port: pcm_valid  in  1  pcm_in valid.
REQ-010 Port: pcm_ready  out  1  FIFO can accept; combinational, equals (count < FIFO_DEPTH).
REQ-011 Port: pdm_out  out  1  registered 1-bit PDM stream: 1 = +FS, 0 = -FS.
REQ-012 Port: sample_tick  out  1  one-clk pulse when a sample is popped from the FIFO.
REQ-013 Port: underflow  out  1  one-clk pulse when a pop is due and the FIFO is empty.
REQ-014 Port: running  out  1  high in state RUN.

Function
REQ-015 Push occurs when pcm_valid && pcm_ready, independent of enable and state.
REQ-016 Push and pop in the same cycle leave count unchanged; pcm_ready is 0 when full, so no push can occur at full.
REQ-017 The block has two states: IDLE and RUN.
REQ-018 IDLE -> RUN when enable=1 and count >= PREFILL; in that cycle: pop head into x_reg, sample_tick=1, phase counter set to 0, int1=int2=0.
REQ-019 RUN -> IDLE on the clk after enable samples 0; int1, int2, x_reg and phase are cleared; FIFO contents are retained.
REQ-020 In IDLE, pdm_out toggles every clk (1,0,1,... idle-zero pattern); sample_tick=0; underflow=0.
REQ-021 In RUN, the phase counter counts 0..R-1 and wraps; at phase R-1 a pop is due.
REQ-022 If a pop is due and count > 0: x_reg <= head, sample_tick pulses on the next cycle.
REQ-023 If a pop is due and count = 0: x_reg is held (last sample repeats), underflow pulses on the next cycle, and the state stays RUN.
REQ-024 The modulator is second-order CIFB, updated every RUN clk using pre-update values.
REQ-025 The quantizer output is y = (int2 >= 0); pdm_out <= y; fb = y ? +FS : -FS, where FS = 2^(IN_WIDTH-1).
REQ-026 int1_next = sat(int1 + x_reg - fb), with int1 of width IN_WIDTH+3.
REQ-027 int2_next = sat(int2 + int1_next - fb), with int2 of width IN_WIDTH+5.
REQ-028 sat() clamps to the signed range of the destination width; no wrap-around is permitted.
REQ-029 A popped sample first affects int1 one clk after the pop; pdm_out reflects int2 one clk after int2 updates.
REQ-030 The ones-density of pdm_out over whole sample periods approximates (1 + x/FS)/2 for |x| <= 0.75*FS.

Reset
REQ-031 While rst_n=0: pdm_out=0, sample_tick=0, underflow=0, running=0, state=IDLE, FIFO count=0 (so pcm_ready=1), int1=int2=x_reg=phase=0.
REQ-032 Reset asserted mid-RUN discards FIFO contents and modulator state immediately; the first cycle after release is IDLE.

Verification
REQ-033 Reset, then hold enable=0 for 6 clk -> pdm_out = 1,0,1,0,1,0; pcm_ready=1; running=0.
REQ-034 enable=0, push 5 samples back-to-back with pcm_valid held high -> 4 accepted; pcm_ready=0 after the 4th; the 5th is held until a pop.
REQ-035 Push 0 continuously and set enable=1 -> running rises once count >= 2; sample_tick every 12 clk; ones in 1200 RUN clk = 600 +/- 2.
REQ-036 Push 16384 (+0.5 FS) continuously and run -> ones in 1200 RUN clk = 900 +/- 4; no underflow.
REQ-037 Push exactly 2 samples and run -> sample_tick at relative cycles 0 and 12, underflow pulse at cycle 24, running stays 1, density tracks the 2nd sample.
REQ-038 Drop enable mid-run with 3 samples queued -> next clk running=0, pdm_out toggling, count=3; re-enable -> running restarts with the queued head.
